// File: rtl/vbsme_pkg.sv
// Shared constants and state encoding for the VBSME minimum-SAD datapath.
package vbsme_pkg;

    localparam int SAD_W = 32;
    localparam logic [SAD_W-1:0] SAD_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sad_min_tracker_if.sv
// Candidate stream, scan control and result bus of the minimum-SAD tracker.
interface sad_min_tracker_if #(
    parameter int POS_W = 6
);
    import vbsme_pkg::*;

    logic             Start;
    logic             InValid;
    logic             InReady;
    logic [SAD_W-1:0] InSad;
    logic [POS_W-1:0] InRow;
    logic [POS_W-1:0] InCol;
    logic             SelNew;
    logic             Busy;
    logic             Done;
    logic [SAD_W-1:0] BestSad;
    logic [POS_W-1:0] BestRow;
    logic [POS_W-1:0] BestCol;

    modport master (
        output Start, InValid, InSad, InRow, InCol,
        input  InReady, SelNew, Busy, Done, BestSad, BestRow, BestCol
    );

    modport slave (
        input  Start, InValid, InSad, InRow, InCol,
        output InReady, SelNew, Busy, Done, BestSad, BestRow, BestCol
    );

endinterface

// File: rtl/sad_compare_select.sv
// Unsigned candidate-vs-best compare and the best-SAD 2-to-1 word mux.
module sad_compare_select
    import vbsme_pkg::*;
(
    input  logic [SAD_W-1:0] in_sad,
    input  logic [SAD_W-1:0] best_sad,
    input  logic             sel_new,
    output logic             lt,
    output logic [SAD_W-1:0] sel_word
);

    assign lt       = (in_sad < best_sad);
    assign sel_word = sel_new ? in_sad : best_sad;

endmodule

// File: rtl/sad_min_tracker.sv
// Streaming minimum-SAD tracker: scan FSM, candidate counter and best-SAD/position registers.
module sad_min_tracker
    import vbsme_pkg::*;
#(
    parameter int NUM_CAND = 4096,
    parameter int POS_W    = 6
) (
    input  logic         Clk,
    input  logic         Reset,
    sad_min_tracker_if.slave bus
);

    localparam int CNT_W = $clog2(NUM_CAND) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CAND - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [POS_W-1:0] best_row_q, best_row_d;
    logic [POS_W-1:0] best_col_q, best_col_d;

    logic             accept_s;
    logic             lt_s;
    logic             sel_new_s;
    logic [SAD_W-1:0] sel_word_s;

    // InReady is high only in SCAN, so a valid candidate in SCAN is always accepted
    assign accept_s  = (state_q == SCAN) && bus.InValid;
    assign sel_new_s = accept_s && lt_s;

    sad_compare_select u_cmp (
        .in_sad   (bus.InSad),
        .best_sad (best_sad_q),
        .sel_new  (sel_new_s),
        .lt       (lt_s),
        .sel_word (sel_word_s)
    );

    // Next-state, counter and best-candidate update
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        best_sad_d = best_sad_q;
        best_row_d = best_row_q;
        best_col_d = best_col_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d    = SCAN;
                    count_d    = {CNT_W{1'b0}};
                    best_sad_d = SAD_INIT;
                    best_row_d = {POS_W{1'b0}};
                    best_col_d = {POS_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (accept_s) begin
                    count_d    = count_q + CNT_W'(1);
                    best_sad_d = sel_word_s;
                    if (sel_new_s) begin
                        best_row_d = bus.InRow;
                        best_col_d = bus.InCol;
                    end else begin
                        best_row_d = best_row_q;
                        best_col_d = best_col_q;
                    end
                    if (count_q == LAST_CNT) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            count_q    <= {CNT_W{1'b0}};
            best_sad_q <= SAD_INIT;
            best_row_q <= {POS_W{1'b0}};
            best_col_q <= {POS_W{1'b0}};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            best_sad_q <= best_sad_d;
            best_row_q <= best_row_d;
            best_col_q <= best_col_d;
        end
    end

    assign bus.InReady = (state_q == SCAN);
    assign bus.Busy    = (state_q == SCAN) || (state_q == DONE);
    assign bus.Done    = (state_q == DONE);
    assign bus.SelNew  = sel_new_s;
    assign bus.BestSad = best_sad_q;
    assign bus.BestRow = best_row_q;
    assign bus.BestCol = best_col_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker across NUM_CAND = 4, 3, 4096 and 1.
module tb_sad_min_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_sad;
    logic [5:0]  in_row;
    logic [5:0]  in_col;
    int          dut_sel;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] sad;
        logic [5:0]  row;
        logic [5:0]  col;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cand_sad[$];
    logic [5:0]  cand_row[$];
    logic [5:0]  cand_col[$];

    always #5 clk = ~clk;

    sad_min_tracker_if #(.POS_W(6)) i4 ();
    sad_min_tracker_if #(.POS_W(6)) i3 ();
    sad_min_tracker_if #(.POS_W(6)) ib ();
    sad_min_tracker_if #(.POS_W(6)) i1 ();

    assign i4.Start = start; assign i4.InValid = in_valid; assign i4.InSad = in_sad;
    assign i4.InRow = in_row; assign i4.InCol = in_col;
    assign i3.Start = start; assign i3.InValid = in_valid; assign i3.InSad = in_sad;
    assign i3.InRow = in_row; assign i3.InCol = in_col;
    assign ib.Start = start; assign ib.InValid = in_valid; assign ib.InSad = in_sad;
    assign ib.InRow = in_row; assign ib.InCol = in_col;
    assign i1.Start = start; assign i1.InValid = in_valid; assign i1.InSad = in_sad;
    assign i1.InRow = in_row; assign i1.InCol = in_col;

    sad_min_tracker #(.NUM_CAND(4),    .POS_W(6)) dut4 (.Clk(clk), .Reset(rst), .bus(i4));
    sad_min_tracker #(.NUM_CAND(3),    .POS_W(6)) dut3 (.Clk(clk), .Reset(rst), .bus(i3));
    sad_min_tracker #(.NUM_CAND(4096), .POS_W(6)) dutb (.Clk(clk), .Reset(rst), .bus(ib));
    sad_min_tracker #(.NUM_CAND(1),    .POS_W(6)) dut1 (.Clk(clk), .Reset(rst), .bus(i1));

    logic [47:0] out4, out3, outb, out1, out_v;
    assign out4 = {i4.InReady, i4.SelNew, i4.Busy, i4.Done, i4.BestSad, i4.BestRow, i4.BestCol};
    assign out3 = {i3.InReady, i3.SelNew, i3.Busy, i3.Done, i3.BestSad, i3.BestRow, i3.BestCol};
    assign outb = {ib.InReady, ib.SelNew, ib.Busy, ib.Done, ib.BestSad, ib.BestRow, ib.BestCol};
    assign out1 = {i1.InReady, i1.SelNew, i1.Busy, i1.Done, i1.BestSad, i1.BestRow, i1.BestCol};

    always_comb begin
        case (dut_sel)
            0:       out_v = out4;
            1:       out_v = out3;
            2:       out_v = outb;
            3:       out_v = out1;
            default: out_v = out4;
        endcase
    end

    logic        o_ready, o_sel_new, o_busy, o_done;
    logic [31:0] o_sad;
    logic [5:0]  o_row, o_col;
    assign {o_ready, o_sel_new, o_busy, o_done, o_sad, o_row, o_col} = out_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_cands();
        cand_sad.delete(); cand_row.delete(); cand_col.delete();
    endtask

    task automatic add_cand(input logic [31:0] s, input logic [5:0] r, input logic [5:0] c);
        cand_sad.push_back(s); cand_row.push_back(r); cand_col.push_back(c);
    endtask

    // Drives one scan from the candidate queues, checking SelNew per candidate against a running-min model
    task automatic run_scan(input string tag, input int stall_at, input int stall_len, input bit mid_start);
        logic [31:0] m_sad;
        logic [5:0]  m_row, m_col;
        logic        exp_sel;
        int          cyc, n, waited;
        exp_t        e;
        m_sad = 32'hFFFF_FFFF; m_row = 6'd0; m_col = 6'd0;
        n = cand_sad.size();
        cyc = 0;
        start = 1'b1;
        tick(); cyc++;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    in_valid = 1'b0;
                    start = mid_start;
                    tick(); cyc++;
                    start = 1'b0;
                end
            end
            in_valid = 1'b1; in_sad = cand_sad[i]; in_row = cand_row[i]; in_col = cand_col[i];
            #1;
            exp_sel = (cand_sad[i] < m_sad);
            total++;
            if (o_sel_new !== exp_sel || o_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s sel_new[%0d]: got sel=%0b rdy=%0b want sel=%0b rdy=1", tag, i, o_sel_new, o_ready, exp_sel);
            end
            if (exp_sel) begin
                m_sad = cand_sad[i]; m_row = cand_row[i]; m_col = cand_col[i];
            end
            tick(); cyc++;
        end
        in_valid = 1'b0;
        e.sad = m_sad; e.row = m_row; e.col = m_col;
        e.cyc = n + 1 + ((stall_at < n) ? stall_len : 0);
        sb.push_back(e);
        waited = 0;
        while (o_done !== 1'b1 && waited < 50) begin
            tick(); cyc++; waited++;
        end
        e = sb.pop_front();
        total++;
        if (o_done !== 1'b1) begin
            bad++;
            $display("FAIL %s done_timeout: got done=%0b want done=1", tag, o_done);
        end else begin
            total++;
            if (cyc != e.cyc) begin
                bad++;
                $display("FAIL %s done_latency: got %0d want %0d", tag, cyc, e.cyc);
            end
            total++;
            if (o_sad !== e.sad || o_row !== e.row || o_col !== e.col || o_busy !== 1'b1 || o_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s result: got sad=%0h row=%0d col=%0d busy=%0b rdy=%0b want sad=%0h row=%0d col=%0d busy=1 rdy=0",
                         tag, o_sad, o_row, o_col, o_busy, o_ready, e.sad, e.row, e.col);
            end
        end
        // Start during DONE must be ignored; Done is a single-cycle pulse and Busy drops next
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done: got done=%0b busy=%0b want done=0 busy=0", tag, o_done, o_busy);
        end
        tick();
        total++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0 || o_sad !== e.sad || o_row !== e.row || o_col !== e.col) begin
            bad++;
            $display("FAIL %s idle_hold: got busy=%0b rdy=%0b sad=%0h want busy=0 rdy=0 sad=%0h", tag, o_busy, o_ready, o_sad, e.sad);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 4; s++) begin
            dut_sel = s;
            #1;
            total++;
            if (out_v !== {4'b0000, 32'hFFFF_FFFF, 12'd0}) begin
                bad++;
                $display("FAIL reset_state[%0d]: got %0h want %0h", s, out_v, {4'b0000, 32'hFFFF_FFFF, 12'd0});
            end
        end
        dut_sel = 0;
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_over_start: got busy=%0b rdy=%0b want 0 0", o_busy, o_ready);
        end
    endtask

    task automatic test_basic();
        do_reset(); dut_sel = 0; clear_cands();
        add_cand(32'd50, 6'd0, 6'd0); add_cand(32'd20, 6'd0, 6'd1);
        add_cand(32'd35, 6'd1, 6'd0); add_cand(32'd40, 6'd1, 6'd1);
        run_scan("basic", 99, 0, 1'b0);
    endtask

    task automatic test_tie();
        do_reset(); dut_sel = 1; clear_cands();
        add_cand(32'd7, 6'd0, 6'd0); add_cand(32'd7, 6'd0, 6'd1); add_cand(32'd9, 6'd0, 6'd2);
        run_scan("tie", 99, 0, 1'b0);
    endtask

    task automatic test_stall_and_start_in_scan();
        do_reset(); dut_sel = 0; clear_cands();
        add_cand(32'd50, 6'd0, 6'd0); add_cand(32'd20, 6'd0, 6'd1);
        add_cand(32'd35, 6'd1, 6'd0); add_cand(32'd40, 6'd1, 6'd1);
        run_scan("stall", 2, 3, 1'b1);
    endtask

    task automatic test_reset_mid_scan();
        do_reset(); dut_sel = 0;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_sad = 32'd5;  in_row = 6'd1; in_col = 6'd2; tick();
        in_valid = 1'b1; in_sad = 32'd10; in_row = 6'd3; in_col = 6'd4; tick();
        rst = 1'b1; in_sad = 32'd0;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (o_sad !== 32'hFFFF_FFFF || o_busy !== 1'b0 || o_ready !== 1'b0 || o_sel_new !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got sad=%0h busy=%0b rdy=%0b sel=%0b want ffffffff 0 0 0", o_sad, o_busy, o_ready, o_sel_new);
        end
        in_valid = 1'b0;
        clear_cands();
        add_cand(32'd90, 6'd2, 6'd2); add_cand(32'd80, 6'd2, 6'd3);
        add_cand(32'd85, 6'd3, 6'd0); add_cand(32'd60, 6'd3, 6'd1);
        run_scan("after_reset", 99, 0, 1'b0);
    endtask

    task automatic test_all_max();
        do_reset(); dut_sel = 0; clear_cands();
        for (int i = 0; i < 4; i++) add_cand(32'hFFFF_FFFF, 6'(i + 1), 6'(i + 5));
        run_scan("all_max", 99, 0, 1'b0);
    endtask

    task automatic test_single();
        do_reset(); dut_sel = 3; clear_cands();
        add_cand(32'd100, 6'd5, 6'd9);
        run_scan("single", 99, 0, 1'b0);
    endtask

    task automatic test_full_size();
        do_reset(); dut_sel = 2; clear_cands();
        for (int i = 0; i < 4096; i++) begin
            if (i == 37 * 64 + 12) add_cand(32'd3, 6'd37, 6'd12);
            else add_cand($urandom_range(32'hFFFF_FFFE, 32'd4), 6'(i / 64), 6'(i % 64));
        end
        run_scan("full", 9999, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_sad = 32'd0; in_row = 6'd0; in_col = 6'd0; dut_sel = 0;
        test_reset();
        test_basic();
        test_tie();
        test_stall_and_start_in_scan();
        test_reset_mid_scan();
        test_all_max();
        test_single();
        test_full_size();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
